store_occupancy_counter: RTL and testbench

- Occupancy counter for a smart-store doorway.
- Two pressure pads, one at the entrance and one at the exit, each generate one event per footstep press.
- Each entrance press adds one person and each exit press removes one; the live head-count is 5 bits.
- Sits between the raw pad inputs and the store display/door-control logic. It provides full/empty status and error pulses.

---
 rtl/store_occupancy_counter_pkg.sv | 16 +
 rtl/store_occupancy_counter_if.sv | 24 ++
 rtl/store_occupancy_counter_pad_edge_sync.sv | 28 ++
 rtl/store_occupancy_counter.sv | 88 ++++++++
 tb/tb_store_occupancy_counter.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/store_occupancy_counter_pkg.sv
// Shared defaults and the occupancy count type, reused by the counter and
// the downstream display/door-control logic.
package store_occupancy_counter_pkg;

  localparam int OCC_WIDTH       = 5;
  localparam int OCC_CAPACITY    = 31;
  localparam int OCC_SYNC_STAGES = 2;

  typedef logic [OCC_WIDTH-1:0] occ_count_t;

  // Largest count representable in a given width.
  function automatic int occ_max(input int width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/store_occupancy_counter_if.sv
// Doorway pad inputs and occupancy status outputs as one bundle.
interface store_occupancy_counter_if #(
  parameter int WIDTH = store_occupancy_counter_pkg::OCC_WIDTH
);
  logic             pressure_in;
  logic             pressure_out;
  logic [WIDTH-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow_err;
  logic             underflow_err;

  // master: pad/test side driving presses and observing status
  modport master (
    output pressure_in, pressure_out,
    input  count, full, empty, overflow_err, underflow_err
  );

  // slave: the counter
  modport slave (
    input  pressure_in, pressure_out,
    output count, full, empty, overflow_err, underflow_err
  );
endinterface

// File: rtl/store_occupancy_counter_pad_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pad followed by a rising-edge
// detector; emits a single-cycle pulse per sampled 0->1 transition.
module pad_edge_sync #(
  parameter int SYNC_STAGES = store_occupancy_counter_pkg::OCC_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], async_in};
      prev      <= sync_pipe[SYNC_STAGES-1];
    end
  end

  // prev clears on reset, so a pad held through reset release fires once.
  assign pulse_out = sync_pipe[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/store_occupancy_counter.sv
// Doorway occupancy counter: synchronized entry/exit pad events drive a
// saturating head-count with registered full/empty flags and error pulses.
module store_occupancy_counter
  import store_occupancy_counter_pkg::*;
#(
  parameter int WIDTH       = OCC_WIDTH,
  parameter int CAPACITY    = OCC_CAPACITY,
  parameter int SYNC_STAGES = OCC_SYNC_STAGES
) (
  input  logic                       clk,
  input  logic                       reset,
  store_occupancy_counter_if.slave   bus
);

  localparam int NUM_PADS = 2;
  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

  generate
    if (CAPACITY > occ_max(WIDTH) || CAPACITY < 1)
      $error("CAPACITY must be in 1 .. 2**WIDTH-1");
    if (SYNC_STAGES < 2)
      $error("SYNC_STAGES must be at least 2");
  endgenerate

  // pad 0 = entrance, pad 1 = exit
  logic [NUM_PADS-1:0] pad_raw;
  logic [NUM_PADS-1:0] pad_evt;

  assign pad_raw = {bus.pressure_out, bus.pressure_in};

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    pad_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pad (
      .clk       (clk),
      .reset     (reset),
      .async_in  (pad_raw[i]),
      .pulse_out (pad_evt[i])
    );
  end

  logic             inc, dec;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             full_q, empty_q, ovf_q, unf_q;
  logic             ovf_nxt, unf_nxt;

  assign inc = pad_evt[0];
  assign dec = pad_evt[1];

  // Simultaneous entry and exit cancel, even at the saturation limits.
  always_comb begin
    count_nxt = count_q;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q == CAP) ovf_nxt   = 1'b1;
        else                count_nxt = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q == '0)  unf_nxt   = 1'b1;
        else                count_nxt = count_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == CAP);
      empty_q <= (count_nxt == '0);
      ovf_q   <= ovf_nxt;
      unf_q   <= unf_nxt;
    end
  end

  assign bus.count         = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;

endmodule

// File: tb/tb_store_occupancy_counter.sv
// Directed bench for the doorway occupancy counter.
module tb_store_occupancy_counter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  int   ovf_cnt;
  int   unf_cnt;
  int   empty_low_cnt;

  store_occupancy_counter_if #(.WIDTH(5)) bus ();

  store_occupancy_counter #(.WIDTH(5), .CAPACITY(31), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock, then sample just after the edge and tally pulse cycles.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (bus.overflow_err)  ovf_cnt++;
      if (bus.underflow_err) unf_cnt++;
      if (!bus.empty)        empty_low_cnt++;
    end
  endtask

  task automatic clr_tally();
    ovf_cnt = 0;
    unf_cnt = 0;
    empty_low_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  // 2 cycles high, then long enough low to settle and re-arm.
  task automatic press_in();
    bus.pressure_in = 1'b1;
    tick(2);
    bus.pressure_in = 1'b0;
    tick(4);
  endtask

  task automatic press_out();
    bus.pressure_out = 1'b1;
    tick(2);
    bus.pressure_out = 1'b0;
    tick(4);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    clr_tally();
    reset = 1'b1;
    bus.pressure_in  = 1'b0;
    bus.pressure_out = 1'b0;
    tick(2);

    // reset state
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_ovf",   32'(bus.overflow_err), 0);
    chk("rst_unf",   32'(bus.underflow_err), 0);
    reset = 1'b0;

    // three entrance presses
    press_in();
    chk("in1_count", 32'(bus.count), 1);
    chk("in1_empty", 32'(bus.empty), 0);
    chk("in1_full",  32'(bus.full), 0);
    press_in();
    chk("in2_count", 32'(bus.count), 2);
    press_in();
    chk("in3_count", 32'(bus.count), 3);

    // latency: count moves on the third edge with the pad sampled high
    bus.pressure_in = 1'b1;
    tick(2);
    chk("lat_edge2", 32'(bus.count), 3);
    tick(1);
    chk("lat_edge3", 32'(bus.count), 4);
    bus.pressure_in = 1'b0;
    tick(4);
    press_out();
    chk("lat_back3", 32'(bus.count), 3);

    // simultaneous entry+exit, then a long exit hold
    clr_tally();
    bus.pressure_in  = 1'b1;
    bus.pressure_out = 1'b1;
    tick(1);
    bus.pressure_in  = 1'b0;
    bus.pressure_out = 1'b0;
    tick(4);
    chk("both_count", 32'(bus.count), 3);
    bus.pressure_out = 1'b1;
    tick(4);
    bus.pressure_out = 1'b0;
    tick(4);
    chk("hold_count", 32'(bus.count), 2);
    chk("hold_ovf",   32'(ovf_cnt), 0);
    chk("hold_unf",   32'(unf_cnt), 0);

    // underflow from empty
    do_reset();
    clr_tally();
    press_out();
    chk("unf_count", 32'(bus.count), 0);
    chk("unf_pulse", 32'(unf_cnt), 1);
    chk("unf_empty_low", 32'(empty_low_cnt), 0);
    chk("unf_ovf",   32'(ovf_cnt), 0);

    // simultaneous at zero: no change, no pulse
    clr_tally();
    bus.pressure_in  = 1'b1;
    bus.pressure_out = 1'b1;
    tick(2);
    bus.pressure_in  = 1'b0;
    bus.pressure_out = 1'b0;
    tick(4);
    chk("both0_count", 32'(bus.count), 0);
    chk("both0_unf",   32'(unf_cnt), 0);

    // fill to capacity, overflow, then one exit
    do_reset();
    clr_tally();
    for (int i = 0; i < 30; i++) press_in();
    chk("fill30_count", 32'(bus.count), 30);
    chk("fill30_full",  32'(bus.full), 0);
    press_in();
    chk("fill31_count", 32'(bus.count), 31);
    chk("fill31_full",  32'(bus.full), 1);
    chk("fill31_ovf",   32'(ovf_cnt), 0);
    press_in();
    chk("ovf_count", 32'(bus.count), 31);
    chk("ovf_pulse", 32'(ovf_cnt), 1);
    chk("ovf_full",  32'(bus.full), 1);
    clr_tally();
    bus.pressure_in  = 1'b1;
    bus.pressure_out = 1'b1;
    tick(2);
    bus.pressure_in  = 1'b0;
    bus.pressure_out = 1'b0;
    tick(4);
    chk("bothcap_count", 32'(bus.count), 31);
    chk("bothcap_ovf",   32'(ovf_cnt), 0);
    press_out();
    chk("exit_count", 32'(bus.count), 30);
    chk("exit_full",  32'(bus.full), 0);

    // reset while entrance is held
    do_reset();
    for (int i = 0; i < 5; i++) press_in();
    chk("pre_rst_count", 32'(bus.count), 5);
    bus.pressure_in = 1'b1;
    tick(3);
    chk("held_count", 32'(bus.count), 6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_empty", 32'(bus.empty), 1);
    tick(2);
    chk("rel_edge2", 32'(bus.count), 0);
    tick(1);
    chk("rel_edge3", 32'(bus.count), 1);
    tick(4);
    chk("rel_hold", 32'(bus.count), 1);
    bus.pressure_in = 1'b0;
    tick(4);

    // glitch between edges is missed; one full period is one event
    bus.pressure_in = 1'b1;
    #2;
    bus.pressure_in = 1'b0;
    tick(5);
    chk("glitch_count", 32'(bus.count), 1);
    bus.pressure_in = 1'b1;
    tick(1);
    bus.pressure_in = 1'b0;
    tick(5);
    chk("period_count", 32'(bus.count), 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
